// File: rtl/vga_timing_gen.sv
`timescale 1ns/1ps
// vga_timing_gen: parametrised raster timing generator.
// Divides clk down to a pixel strobe, scans h/v counters, and drives registered
// sync / display-enable / coordinate outputs plus line/frame start pulses.
// Stopping only happens on a frame boundary, so a partial frame is never emitted.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 29,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CLK_DIV  = 4,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          pix_ce,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          line_start,
  output logic          frame_start,
  output logic          busy
);

  // state   | meaning
  // S_IDLE  | counters parked at (0,0), outputs at reset values, waiting for en
  // S_RUN   | normal scan, en high
  // S_DRAIN | en dropped; finish the current frame, then stop unless en returns

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_STOP  = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_STOP  = VS_START + V_SYNC;
  localparam int DW       = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic HS_ACT = (HS_POL != 0);
  localparam logic VS_ACT = (VS_POL != 0);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q;
  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q;
  logic [CW-1:0] h_q, v_q, h_d, v_d;
  logic          h_wrap, v_wrap, frame_end;
  logic [CW-1:0] tgt_h, tgt_v;
  logic          dec_hs, dec_vs, dec_de;
  logic [CW-1:0] dec_col, dec_row;
  logic          hsync_q, vsync_q, de_q, line_start_q, frame_start_q, busy_q;
  logic [CW-1:0] col_q, row_q;

  // Next divider count; wraps at CLK_DIV-1
  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + DW'(1);
  end

  // Free-running divider; pix_ce is registered so it is high while div_q==CLK_DIV-1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= (div_d == DIV_LAST);
    end
  end

  // Raster counter increments and the coordinate the outputs will describe next
  always_comb begin
    h_wrap    = (h_q == CW'(H_TOTAL - 1));
    v_wrap    = (v_q == CW'(V_TOTAL - 1));
    frame_end = h_wrap && v_wrap;
    h_d       = h_wrap ? '0 : h_q + CW'(1);
    v_d       = v_q;
    if (h_wrap) begin
      v_d = v_wrap ? '0 : v_q + CW'(1);
    end
    // Leaving IDLE shows pixel (0,0) without advancing the parked counters
    tgt_h = (state_q == S_IDLE) ? '0 : h_d;
    tgt_v = (state_q == S_IDLE) ? '0 : v_d;
  end

  // Sync / enable / coordinate decode of the target pixel
  always_comb begin
    dec_hs  = (tgt_h >= CW'(HS_START) && tgt_h < CW'(HS_STOP)) ? HS_ACT : ~HS_ACT;
    dec_vs  = (tgt_v >= CW'(VS_START) && tgt_v < CW'(VS_STOP)) ? VS_ACT : ~VS_ACT;
    dec_de  = (tgt_h < CW'(H_ACTIVE)) && (tgt_v < CW'(V_ACTIVE));
    dec_col = (tgt_h < CW'(H_ACTIVE)) ? tgt_h : '0;
    dec_row = (tgt_v < CW'(V_ACTIVE)) ? tgt_v : '0;
  end

  // Scan FSM with counters and all registered raster outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      h_q           <= '0;
      v_q           <= '0;
      hsync_q       <= ~HS_ACT;
      vsync_q       <= ~VS_ACT;
      de_q          <= 1'b0;
      col_q         <= '0;
      row_q         <= '0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      if (pix_ce_q) begin
        case (state_q)
          S_IDLE: begin
            if (en) begin
              state_q       <= S_RUN;
              hsync_q       <= dec_hs;
              vsync_q       <= dec_vs;
              de_q          <= dec_de;
              col_q         <= dec_col;
              row_q         <= dec_row;
              line_start_q  <= 1'b1;
              frame_start_q <= 1'b1;
              busy_q        <= 1'b1;
            end
          end
          S_RUN, S_DRAIN: begin
            h_q <= h_d;
            v_q <= v_d;
            // en low on the last pixel of a frame: that frame is complete, stop here
            if (frame_end && !en) begin
              state_q <= S_IDLE;
              hsync_q <= ~HS_ACT;
              vsync_q <= ~VS_ACT;
              de_q    <= 1'b0;
              col_q   <= '0;
              row_q   <= '0;
              busy_q  <= 1'b0;
            end else begin
              state_q       <= en ? S_RUN : S_DRAIN;
              hsync_q       <= dec_hs;
              vsync_q       <= dec_vs;
              de_q          <= dec_de;
              col_q         <= dec_col;
              row_q         <= dec_row;
              line_start_q  <= h_wrap;
              frame_start_q <= frame_end;
              busy_q        <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign pix_ce      = pix_ce_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign col         = col_q;
  assign row         = row_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
`timescale 1ns/1ps
// Bench for vga_timing_gen using a small raster so many frames fit in a short run.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 3, HB = 2;
  localparam int VA = 5, VF = 1, VSW = 2, VB = 1;
  localparam int HT = HA + HF + HSW + HB;   // 15
  localparam int VT = VA + VF + VSW + VB;   // 9
  localparam int D  = 3;
  localparam int CW = 8;
  localparam bit HSP = 1'b0;
  localparam bit VSP = 1'b1;

  logic clk, rst, en;
  logic pix_ce, hsync, vsync, de, line_start, frame_start, busy;
  logic [CW-1:0] col, row;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(0), .VS_POL(1), .CLK_DIV(D), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .en(en),
    .pix_ce(pix_ce), .hsync(hsync), .vsync(vsync), .de(de),
    .col(col), .row(row),
    .line_start(line_start), .frame_start(frame_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  bit chk_en  = 1'b0;

  // Reference: k clocks since reset; a pixel step happens on the edge after a strobe cycle.
  int k;
  bit m_act, m_ls, m_fs, m_step;
  int mh, mv;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      k = 0; m_act = 0; mh = 0; mv = 0; m_ls = 0; m_fs = 0;
    end else begin
      m_step = (k >= 1) && ((k % D) == D - 1);
      k = k + 1;
      m_ls = 0;
      m_fs = 0;
      if (m_step) begin
        if (!m_act) begin
          if (en) begin
            m_act = 1; mh = 0; mv = 0; m_ls = 1; m_fs = 1;
          end
        end else begin
          mh = mh + 1;
          if (mh == HT) begin
            mh = 0;
            mv = (mv + 1) % VT;
          end
          if (mh == 0 && mv == 0 && !en) begin
            m_act = 0;
          end else begin
            m_ls = (mh == 0);
            m_fs = (mh == 0) && (mv == 0);
          end
        end
      end
    end
  end

  function automatic logic [22:0] model_out();
    logic pce, hs, vs, d;
    logic [7:0] c, r;
    pce = (k >= 1) && ((k % D) == D - 1);
    if (m_act) begin
      hs = (mh >= HA + HF && mh < HA + HF + HSW) ? HSP : !HSP;
      vs = (mv >= VA + VF && mv < VA + VF + VSW) ? VSP : !VSP;
      d  = (mh < HA) && (mv < VA);
      c  = (mh < HA) ? 8'(mh) : 8'd0;
      r  = (mv < VA) ? 8'(mv) : 8'd0;
    end else begin
      hs = !HSP; vs = !VSP; d = 0; c = 0; r = 0;
    end
    return {pce, hs, vs, d, c, r, m_ls, m_fs, m_act};
  endfunction

  // Every-cycle comparison against the reference
  always @(negedge clk) begin
    if (chk_en) begin
      logic [22:0] got, exp;
      got = {pix_ce, hsync, vsync, de, col, row, line_start, frame_start, busy};
      exp = model_out();
      vectors++;
      if (got !== exp) begin
        errors++;
        $display("FAIL model_compare t=%0t got={pce,hs,vs,de,col,row,ls,fs,busy}=%h expected=%h", $time, got, exp);
      end
    end
  end

  task automatic chk(input string nm, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", nm, got, exp);
    end
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0:       return frame_start;
      1:       return line_start;
      2:       return de && (col == 8'd3);
      default: return pix_ce;
    endcase
  endfunction

  // Waits for a condition at negedges; n = negedges waited, or -1 if the budget ran out
  task automatic wait_sig(input int sel, input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (sig(sel)) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hold;
    int de_c, hs_c, vs_c, ls_c, ls_first, ls_second, fs_at, fs_c;

    assert ((HT - 1) < (1 << CW) && (VT - 1) < (1 << CW))
    else begin
      $display("FAIL cw_width counters do not fit CW=%0d", CW);
      $fatal(1, "CW too small");
    end

    rst = 1'b1; en = 1'b0;
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_hsync", hsync, 1);
    chk("rst_vsync", vsync, 0);
    chk("rst_de", de, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pix_ce", pix_ce, 0);
    rst = 1'b0;

    // Strobe period while idle
    wait_sig(3, 10, n);
    chk("pix_ce_first", n, D - 1);
    wait_sig(3, 10, n);
    chk("pix_ce_period", n, D);

    // Full-frame statistics with en held high
    en = 1'b1;
    wait_sig(0, 2 * D + 2, n);
    chk("fs_after_enable_found", (n > 0) ? 1 : 0, 1);
    de_c = 0; hs_c = 0; vs_c = 0; ls_c = 0; ls_first = -1; ls_second = -1; fs_at = -1;
    for (int i = 0; i < 405; i++) begin
      if (i > 0) @(negedge clk);
      if (de) de_c++;
      if (hsync == 1'b0) hs_c++;
      if (vsync == 1'b1) vs_c++;
      if (line_start) begin
        ls_c++;
        if (ls_first < 0) ls_first = i;
        else if (ls_second < 0) ls_second = i;
      end
      if (i > 0 && frame_start && fs_at < 0) fs_at = i;
    end
    @(negedge clk);
    if (frame_start && fs_at < 0) fs_at = 405;
    chk("frame_period", fs_at, 405);
    chk("line_starts_per_frame", ls_c, 9);
    chk("line_period", ls_second - ls_first, 45);
    chk("de_clks_per_frame", de_c, 120);
    chk("hsync_active_clks", hs_c, 81);
    chk("vsync_active_clks", vs_c, 90);

    // en dropped and restored inside one frame: period unchanged
    n = -1;
    for (int i = 1; i <= 450; i++) begin
      @(negedge clk);
      if (i == 100) en = 1'b0;
      if (i == 160) en = 1'b1;
      if (frame_start) begin
        n = i;
        break;
      end
    end
    chk("glitchless_reenable_period", n, 405);

    // en dropped mid-frame: frame completes, then stop with no frame_start
    wait_sig(1, 100, n);
    wait_sig(1, 100, n);
    wait_sig(1, 100, n);
    en = 1'b0;
    fs_c = 0; n = -1;
    for (int i = 1; i <= 810; i++) begin
      @(negedge clk);
      if (frame_start) fs_c++;
      if (!busy) begin
        n = i;
        break;
      end
    end
    chk("drain_reaches_idle", (n > 0) ? 1 : 0, 1);
    chk("drain_no_frame_start", fs_c, 0);
    chk("idle_hsync", hsync, 1);
    chk("idle_vsync", vsync, 0);
    chk("idle_de", de, 0);
    fs_c = 0;
    repeat (60) begin
      @(negedge clk);
      if (frame_start || busy) fs_c++;
    end
    chk("idle_stays_stopped", fs_c, 0);
    en = 1'b1;
    wait_sig(0, D, n);
    chk("restart_fs_within_div", (n > 0) ? 1 : 0, 1);

    // Async reset in the middle of an active line
    wait_sig(2, 500, n);
    chk("found_active_pixel", (n > 0) ? 1 : 0, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_de", de, 0);
    chk("async_rst_col", col, 0);
    chk("async_rst_row", row, 0);
    chk("async_rst_hsync", hsync, 1);
    chk("async_rst_vsync", vsync, 0);
    chk("async_rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_sig(0, D, n);
    chk("post_rst_fs_within_div", (n > 0) ? 1 : 0, 1);

    // Randomised en activity with occasional async resets
    for (int it = 0; it < 40; it++) begin
      en = ($urandom_range(0, 3) != 0);
      hold = $urandom_range(1, 500);
      repeat (hold) @(negedge clk);
      if ($urandom_range(0, 9) == 0) begin
        #($urandom_range(1, 4));
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    repeat (5) @(negedge clk);
    chk_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator that succeeds the fixed 640x480 sync FSM. It derives a pixel strobe from the system clock and drives h/v sync with configurable polarity, display-enable, and active-area col/row coordinates. It also emits line-start and frame-start pulses for the frame-buffer reader, and supports run/stop gated on frame boundaries. It sits between the system clock domain and the VGA pins/pixel fetch logic.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 29, vertical back porch (lines)
HS_POL, 0, hsync active level (0 = active-low)
VS_POL, 0, vsync active level
CLK_DIV, 4, system clocks per pixel (>=1)
CW, 12, width of internal counters and col/row outputs

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
en  input  1  run request; level-sensitive
pix_ce  output  1  one-clk pixel strobe, every CLK_DIV clocks
hsync  output  1  horizontal sync, polarity HS_POL
vsync  output  1  vertical sync, polarity VS_POL
de  output  1  high while the current pixel is in the active area
col  output  CW  active-area x coordinate, 0..H_ACTIVE-1
row  output  CW  active-area y coordinate, 0..V_ACTIVE-1
line_start  output  1  one-clk pulse when h_cnt enters 0 (RUN only)
frame_start  output  1  one-clk pulse when (h_cnt,v_cnt) enters (0,0) (RUN only)
busy  output  1  high in RUN or DRAIN

Behaviour:
- One clock, clk. Reset is asynchronous and active-high (rst). All outputs are registered.
- Reset values: hsync=!HS_POL, vsync=!VS_POL, de=0, col=0, row=0, pix_ce=0, line_start=0, frame_start=0, busy=0, state=IDLE, h_cnt=v_cnt=0, div_cnt=0.
- Divider: div_cnt free-runs 0..CLK_DIV-1 from reset in every state. pix_ce=1 in the cycle where div_cnt==CLK_DIV-1. With CLK_DIV=1, pix_ce is high every cycle after reset release.
- H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise. Line layout (h_cnt): [0,H_ACTIVE) active, then FP, then sync [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), then BP. Vertical layout uses the same structure.
- Counters advance only on pix_ce. When h_cnt==H_TOTAL-1, h_cnt wraps to 0 and v_cnt increments. When v_cnt==V_TOTAL-1 at that point, v_cnt also wraps to 0.
- Decode is registered together with the counters. hsync, vsync, de, col and row describe the same pixel, with zero skew between them. They change only in the cycle after a pix_ce edge.
- col=h_cnt when h_cnt<H_ACTIVE, else 0. row=v_cnt when v_cnt<V_ACTIVE, else 0. de=(h_cnt<H_ACTIVE)&&(v_cnt<V_ACTIVE).
- FSM:
  - IDLE: counters held at 0, outputs at reset values. On a pix_ce with en=1, go to RUN. The first RUN pixel is (0,0), and frame_start and line_start pulse for one clk.
  - RUN: normal scan. If en=0 is sampled on any pix_ce, go to DRAIN.
  - DRAIN: scan continues to the end of the frame. If en=1 returns before the wrap, go back to RUN with no glitch. At the pix_ce wrapping (H_TOTAL-1,V_TOTAL-1) with en=0, go to IDLE; outputs take reset values and no frame_start is issued. If en=1 at that wrap, continue in RUN and issue frame_start.
- A stopped frame is always complete; a partial frame is never emitted, except when rst asserts.
- rst mid-frame: all outputs return to reset values immediately (async). After release, the block waits in IDLE for en.
- Simultaneous line_start and frame_start at (0,0): both pulse high in the same cycle.
- CW must hold H_TOTAL-1 and V_TOTAL-1. This is not checked in RTL; the bench asserts it.

Test Plan:
- Default params, CLK_DIV=4, en=1 from reset: frame_start period = 800*521*4 = 1,667,200 clks; line_start period = 3,200 clks; pix_ce period = 4 clks.
- Default params, hsync check: hsync=0 exactly for h_cnt 656..751 (96 pixels), high elsewhere. vsync=0 only during lines 490..491. Total de pixels per frame = 307,200.
- HS_POL=1, VS_POL=1, CLK_DIV=1, tiny timing (H 4/1/2/1, V 3/1/1/1): hsync is high only at h=5..6, vsync is high only at v=4. col sequence per active line is 0,1,2,3,0,0,0,0.
- Default params, en dropped at line 100: scan continues to the end of frame, then busy=0, with hsync/vsync inactive and de=0. No frame_start follows. Re-asserting en gives frame_start on the next pix_ce.
- en dropped then re-asserted within the same frame: no interruption, and frame_start period stays unchanged at 1,667,200.
- rst pulsed mid-line with de=1: in the same cycle, de=0, col=row=0, and hsync/vsync inactive. After release with en=1, the first frame_start occurs within CLK_DIV clocks.
